// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: FWFT FIFO of retired instructions plus
// instret/cycle/drop counters and a no-retire hang watchdog.
module retire_trace_buffer #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire,
    input  logic [XLEN-1:0]            ret_pc,
    input  logic [31:0]                ret_instr,
    input  logic [4:0]                 ret_rd,
    input  logic                       ret_we,
    input  logic [XLEN-1:0]            ret_wdata,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [4:0]                 out_rd,
    output logic                       out_we,
    output logic [XLEN-1:0]            out_wdata,
    output logic [CNT_W-1:0]           instret,
    output logic [CNT_W-1:0]           cycles,
    output logic [CNT_W-1:0]           dropped,
    output logic                       overflow,
    output logic                       hang,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [IW-1:0] TO_MAX   = IW'(TIMEOUT);
    localparam logic [IW-1:0] TO_LAST  = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HUNG
    } wd_state_t;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic            mem_we    [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [IW-1:0] idle;
    wd_state_t     state;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign out_valid = (level != '0);
    assign full      = (level == FULL_LVL);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a retire when the head leaves this cycle
    assign push      = retire & (~full | pop);
    assign drop      = retire & full & ~pop;

    assign out_pc    = mem_pc[rptr];
    assign out_instr = mem_instr[rptr];
    assign out_rd    = mem_rd[rptr];
    assign out_we    = mem_we[rptr];
    assign out_wdata = mem_wdata[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wptr]    <= ret_pc;
            mem_instr[wptr] <= ret_instr;
            mem_rd[wptr]    <= ret_rd;
            mem_we[wptr]    <= ret_we;
            mem_wdata[wptr] <= ret_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Clear dominates, so a drop in the clear cycle leaves no trace
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret  <= '0;
            cycles   <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            instret  <= '0;
            cycles   <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else begin
            instret  <= instret + CNT_W'(retire);
            cycles   <= cycles + CNT_W'(1);
            dropped  <= dropped + CNT_W'(drop);
            overflow <= overflow | drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idle  <= '0;
            hang  <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            idle  <= '0;
            hang  <= 1'b0;
        end else if (retire) begin
            idle <= '0;
            if (state != HUNG)
                state <= RUN;
        end else if (idle != TO_MAX) begin
            idle <= idle + IW'(1);
            if (idle == TO_LAST) begin
                hang  <= 1'b1;
                state <= HUNG;
            end
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer
// (DEPTH=8, TIMEOUT=64).
module tb_retire_trace_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        retire;
    logic [31:0] ret_pc;
    logic [31:0] ret_instr;
    logic [4:0]  ret_rd;
    logic        ret_we;
    logic [31:0] ret_wdata;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [31:0] out_wdata;
    logic [31:0] instret;
    logic [31:0] cycles;
    logic [31:0] dropped;
    logic        overflow;
    logic        hang;
    logic [3:0]  level;

    int errors = 0;
    int checks = 0;

    retire_trace_buffer #(
        .XLEN(32), .DEPTH(8), .CNT_W(32), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .retire(retire),
        .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_rd(ret_rd),
        .ret_we(ret_we), .ret_wdata(ret_wdata), .clear(clear),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd),
        .out_we(out_we), .out_wdata(out_wdata), .instret(instret),
        .cycles(cycles), .dropped(dropped), .overflow(overflow),
        .hang(hang), .level(level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        retire = 0; clear = 0; out_ready = 0;
        ret_pc = 0; ret_instr = 0; ret_rd = 0; ret_we = 0; ret_wdata = 0;
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] rd, input logic [31:0] wdata);
        retire = 1; ret_pc = pc; ret_instr = instr;
        ret_rd = rd; ret_we = 1; ret_wdata = wdata;
        step();
        retire = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (instret !== 32'd0 || dropped !== 32'd0) begin errors++; $display("FAIL reset_cnt instret=%0d dropped=%0d exp 0", instret, dropped); end
        checks++; if (hang !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags hang=%b ovf=%b exp 0", hang, overflow); end
        step();
        checks++; if (cycles !== 32'd1) begin errors++; $display("FAIL reset_cycle1 got %0d exp 1", cycles); end
    endtask

    task automatic test_single();
        do_reset();
        push_one(32'h0, 32'h00010093, 5'd1, 32'd42);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL single_pc got %h exp 0", out_pc); end
        checks++; if (out_instr !== 32'h00010093) begin errors++; $display("FAIL single_instr got %h exp 00010093", out_instr); end
        checks++; if (out_wdata !== 32'd42 || out_rd !== 5'd1 || out_we !== 1'b1) begin errors++; $display("FAIL single_wb got wdata=%0d rd=%0d we=%b exp 42 1 1", out_wdata, out_rd, out_we); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL single_instret got %0d exp 1", instret); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    endtask

    task automatic test_order();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_wd [3];
        exp_pc[0] = 32'd0; exp_pc[1] = 32'd4; exp_pc[2] = 32'd8;
        exp_wd[0] = 32'd42; exp_wd[1] = 32'd46; exp_wd[2] = 32'd34;
        do_reset();
        for (int i = 0; i < 3; i++)
            push_one(exp_pc[i], 32'h13, 5'(i + 1), exp_wd[i]);
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL order_level got %0d exp 3", level); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_wdata !== exp_wd[i]) begin errors++; $display("FAIL order_pop%0d got v=%b pc=%0d wd=%0d exp 1 %0d %0d", i, out_valid, out_pc, out_wdata, exp_pc[i], exp_wd[i]); end
            step();
        end
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 10; i++)
            push_one(32'(i * 4), 32'h13, 5'd2, 32'(i));
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
        checks++; if (dropped !== 32'd2) begin errors++; $display("FAIL ovf_dropped got %0d exp 2", dropped); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (instret !== 32'd10) begin errors++; $display("FAIL ovf_instret got %0d exp 10", instret); end
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL ovf_head got %0d exp 0", out_pc); end
        out_ready = 1;
        push_one(32'h100, 32'h13, 5'd3, 32'd7);
        checks++; if (level !== 4'd8 || dropped !== 32'd2) begin errors++; $display("FAIL ovf_pushpop level=%0d dropped=%0d exp 8 2", level, dropped); end
        checks++; if (out_pc !== 32'd4) begin errors++; $display("FAIL ovf_head2 got %0d exp 4", out_pc); end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 32'((i + 1) * 4) : 32'h100;
            checks++; if (out_valid !== 1'b1 || out_pc !== exp) begin errors++; $display("FAIL ovf_drain%0d got v=%b pc=%h exp 1 %h", i, out_valid, out_pc, exp); end
            step();
        end
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_clear_retire();
        do_reset();
        for (int i = 0; i < 9; i++)
            push_one(32'(i * 4), 32'h13, 5'd4, 32'(i));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got %b exp 1", overflow); end
        clear = 1;
        push_one(32'h200, 32'h13, 5'd4, 32'd9);
        clear = 0;
        checks++; if (instret !== 32'd0 || cycles !== 32'd0) begin errors++; $display("FAIL clr_cnt instret=%0d cycles=%0d exp 0 0", instret, cycles); end
        checks++; if (dropped !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clr_drop dropped=%0d ovf=%b exp 0 0", dropped, overflow); end
        checks++; if (level !== 4'd8 || out_pc !== 32'd0) begin errors++; $display("FAIL clr_fifo level=%0d head=%0d exp 8 0", level, out_pc); end
    endtask

    task automatic test_hang();
        int early;
        early = 0;
        do_reset();
        for (int i = 1; i < 64; i++) begin
            step();
            if (hang !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL hang_early got %0d early edges exp 0", early); end
        step();
        checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_set got %b exp 1", hang); end
        push_one(32'h40, 32'h13, 5'd5, 32'd1);
        checks++; if (hang !== 1'b1 || instret !== 32'd1) begin errors++; $display("FAIL hang_sticky hang=%b instret=%0d exp 1 1", hang, instret); end
        clear = 1;
        step();
        clear = 0;
        checks++; if (hang !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL hang_clear hang=%b instret=%0d exp 0 0", hang, instret); end
        for (int i = 0; i < 63; i++)
            step();
        checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_rearm63 got %b exp 0", hang); end
        step();
        checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_rearm64 got %b exp 1", hang); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            push_one(32'h1000 + 32'(i * 4), 32'(i), 5'(i), ~32'(i));
            checks++; if (level !== 4'd1 || out_pc !== 32'h1000 + 32'(i * 4) || out_wdata !== ~32'(i)) begin errors++; $display("FAIL wrap_head%0d level=%0d pc=%h wd=%h", i, level, out_pc, out_wdata); end
            out_ready = 1;
            step();
            out_ready = 0;
            checks++; if (level !== 4'd0) begin errors++; $display("FAIL wrap_pop%0d got level %0d exp 0", i, level); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_one(32'h500, 32'h13, 5'd6, 32'd0);
        out_ready = 1;
        for (int i = 1; i < 12; i++) begin
            push_one(32'h500 + 32'(i * 4), 32'h13, 5'd6, 32'(i));
            checks++; if (level !== 4'd1 || out_pc !== 32'h500 + 32'(i * 4)) begin errors++; $display("FAIL b2b_%0d level=%0d pc=%h exp 1 %h", i, level, out_pc, 32'h500 + 32'(i * 4)); end
        end
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++)
            push_one(32'(i * 4), 32'h13, 5'd7, 32'(i));
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_pre_level got %0d exp 5", level); end
        reset = 1;
        #2;
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL mid_fifo v=%b level=%0d exp 0 0", out_valid, level); end
        checks++; if (instret !== 32'd0 || cycles !== 32'd0) begin errors++; $display("FAIL mid_cnt instret=%0d cycles=%0d exp 0 0", instret, cycles); end
        step();
        reset = 0;
        step();
        checks++; if (out_valid !== 1'b0 || cycles !== 32'd1) begin errors++; $display("FAIL mid_after v=%b cycles=%0d exp 0 1", out_valid, cycles); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_clear_retire();
        test_hang();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
